psram_cmd_sequencer: RTL

Command-level stage directly upstream of the PSRAM SPI byte interface. After reset it runs the PSRAM power-up and init sequence in 1-bit SPI mode, then turns host byte read/write requests into QPI frames:
- write frame: 0x38 + 3 address bytes + data
- read frame: 0xEB + 3 address bytes + dummy cycles + data

It issues one byte-operation at a time to the SPI interface, waits for its done pulse, and drives chip-enable framing.

---
 rtl/psram_cmd_sequencer_if.sv | 52 +++++
 rtl/psram_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : psram_cmd_sequencer_if
// Brief    : Host request/response and SPI byte-op signals for the PSRAM
//            command sequencer. PSRAM_BURST_EN adds req_len and wdata_pop.
// Revision : 1.0 - initial release
// ============================================================================
interface psram_cmd_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [22:0] req_addr;
   logic [7:0]  req_wdata;
`ifdef PSRAM_BURST_EN
   logic [1:0]  req_len;
   logic        wdata_pop;
`endif
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        init_done;
   logic        spi_start;
   logic [1:0]  spi_op;
   logic [7:0]  spi_tx_byte;
   logic        spi_done;
   logic [7:0]  spi_rx_byte;
   logic        spi_ce;

`ifdef PSRAM_BURST_EN
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_len, spi_done, spi_rx_byte,
      output req_ready, rsp_valid, rsp_rdata, init_done, wdata_pop,
             spi_start, spi_op, spi_tx_byte, spi_ce
   );
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_len, spi_done, spi_rx_byte,
      input  req_ready, rsp_valid, rsp_rdata, init_done, wdata_pop,
             spi_start, spi_op, spi_tx_byte, spi_ce
   );
`else
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, spi_done, spi_rx_byte,
      output req_ready, rsp_valid, rsp_rdata, init_done,
             spi_start, spi_op, spi_tx_byte, spi_ce
   );
   modport master (
      output req_valid, req_we, req_addr, req_wdata, spi_done, spi_rx_byte,
      input  req_ready, rsp_valid, rsp_rdata, init_done,
             spi_start, spi_op, spi_tx_byte, spi_ce
   );
`endif
endinterface
`default_nettype wire

// File: rtl/psram_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : psram_cmd_sequencer
// Brief    : PSRAM power-up/init in SPI mode, then host byte requests turned
//            into QPI 0x38 / 0xEB frames, one SPI byte-op at a time.
//            Optional macro PSRAM_BURST_EN: 1..4 byte bursts per frame.
// Revision : 1.0 - initial release
// ============================================================================
module psram_cmd_sequencer #(
   parameter int POWERUP_CYCLES = 15000,
   parameter int CE_HIGH_CYCLES = 4,
   parameter int READ_WAIT_OPS  = 3
) (
   input  wire                  sysclk,
   input  wire                  reset_n,
   psram_cmd_sequencer_if.slave bus
);

   localparam logic [1:0] c_OP_SPI  = 2'b00;
   localparam logic [1:0] c_OP_QRD  = 2'b01;
   localparam logic [1:0] c_OP_QWR  = 2'b10;
   localparam logic [1:0] c_OP_WAIT = 2'b11;

   localparam logic [3:0] c_PWRUP  = 4'd0;
   localparam logic [3:0] c_RSTEN  = 4'd1;
   localparam logic [3:0] c_GAP1   = 4'd2;
   localparam logic [3:0] c_RST    = 4'd3;
   localparam logic [3:0] c_GAP2   = 4'd4;
   localparam logic [3:0] c_QPI_EN = 4'd5;
   localparam logic [3:0] c_GAP3   = 4'd6;
   localparam logic [3:0] c_IDLE   = 4'd7;
   localparam logic [3:0] c_CMD    = 4'd8;
   localparam logic [3:0] c_ADDR2  = 4'd9;
   localparam logic [3:0] c_ADDR1  = 4'd10;
   localparam logic [3:0] c_ADDR0  = 4'd11;
   localparam logic [3:0] c_DUMMY  = 4'd12;
   localparam logic [3:0] c_DATA   = 4'd13;
   localparam logic [3:0] c_DONE   = 4'd14;
   localparam logic [3:0] c_GAP    = 4'd15;

   localparam int c_CNT_MAX = (POWERUP_CYCLES > CE_HIGH_CYCLES) ? POWERUP_CYCLES : CE_HIGH_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_PWRUP_LAST = c_CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(CE_HIGH_CYCLES - 1);
   localparam int c_DUM_W = (READ_WAIT_OPS > 1) ? $clog2(READ_WAIT_OPS) : 1;
   localparam logic [c_DUM_W-1:0] c_DUM_LAST =
      c_DUM_W'((READ_WAIT_OPS > 0) ? READ_WAIT_OPS - 1 : 0);

   logic [3:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_DUM_W-1:0] r_dum;
   logic               r_busy;
   logic [22:0]        r_addr;
   logic               r_we;
   logic [7:0]         r_wdata;
   logic               r_start;
   logic [1:0]         r_op;
   logic [7:0]         r_tx;
   logic               r_ce;
   logic               r_rsp_valid;
   logic [7:0]         r_rdata;
   logic               r_init_done;
`ifdef PSRAM_BURST_EN
   logic [1:0]         r_len;
   logic [1:0]         r_beat;
   logic               r_pop;
`endif

   logic [3:0] w_next;
   logic       w_launch;
   logic [1:0] w_op;
   logic [7:0] w_byte;
   logic       w_done;
   logic       w_ready;
   logic       w_accept;
   logic       w_gap_hit;
   logic       w_counting;
   logic       w_ce_low_next;
   logic       w_data_last;

   // A done pulse only counts while an op we launched is still outstanding.
   assign w_done     = bus.spi_done & r_busy;
   assign w_ready    = (r_state == c_IDLE) & r_ce;
   assign w_accept   = bus.req_valid & w_ready;
   assign w_gap_hit  = (r_cnt == c_GAP_LAST);
   assign w_counting = r_state inside {c_PWRUP, c_GAP1, c_GAP2, c_GAP3, c_GAP};
   assign w_ce_low_next = w_next inside {c_RSTEN, c_RST, c_QPI_EN, c_CMD, c_ADDR2,
                                         c_ADDR1, c_ADDR0, c_DUMMY, c_DATA};
`ifdef PSRAM_BURST_EN
   assign w_data_last = (r_beat == r_len);
`else
   assign w_data_last = 1'b1;
`endif

   // Every op launch happens on the edge that enters (or re-enters) its state,
   // so back-to-back ops start the cycle after the previous done.
   always_comb begin
      w_next   = r_state;
      w_launch = 1'b0;
      w_op     = c_OP_SPI;
      w_byte   = 8'h00;
      case (r_state)
         c_PWRUP: begin
            if (r_cnt == c_PWRUP_LAST) begin
               w_next   = c_RSTEN;
               w_launch = 1'b1;
               w_byte   = 8'h66;
            end
         end
         c_RSTEN: begin
            if (w_done) w_next = c_GAP1;
         end
         c_GAP1: begin
            if (w_gap_hit) begin
               w_next   = c_RST;
               w_launch = 1'b1;
               w_byte   = 8'h99;
            end
         end
         c_RST: begin
            if (w_done) w_next = c_GAP2;
         end
         c_GAP2: begin
            if (w_gap_hit) begin
               w_next   = c_QPI_EN;
               w_launch = 1'b1;
               w_byte   = 8'h35;
            end
         end
         c_QPI_EN: begin
            if (w_done) w_next = c_GAP3;
         end
         c_GAP3: begin
            if (w_gap_hit) w_next = c_IDLE;
         end
         c_IDLE: begin
            if (w_accept) begin
               w_next   = c_CMD;
               w_launch = 1'b1;
               w_op     = c_OP_QWR;
               w_byte   = bus.req_we ? 8'h38 : 8'hEB;
            end
         end
         c_CMD: begin
            if (w_done) begin
               w_next   = c_ADDR2;
               w_launch = 1'b1;
               w_op     = c_OP_QWR;
               w_byte   = {1'b0, r_addr[22:16]};
            end
         end
         c_ADDR2: begin
            if (w_done) begin
               w_next   = c_ADDR1;
               w_launch = 1'b1;
               w_op     = c_OP_QWR;
               w_byte   = r_addr[15:8];
            end
         end
         c_ADDR1: begin
            if (w_done) begin
               w_next   = c_ADDR0;
               w_launch = 1'b1;
               w_op     = c_OP_QWR;
               w_byte   = r_addr[7:0];
            end
         end
         c_ADDR0: begin
            if (w_done) begin
               w_launch = 1'b1;
               if (r_we) begin
                  w_next = c_DATA;
                  w_op   = c_OP_QWR;
                  w_byte = r_wdata;
               end else if (READ_WAIT_OPS == 0) begin
                  w_next = c_DATA;
                  w_op   = c_OP_QRD;
               end else begin
                  w_next = c_DUMMY;
                  w_op   = c_OP_WAIT;
               end
            end
         end
         c_DUMMY: begin
            if (w_done) begin
               w_launch = 1'b1;
               if (r_dum == c_DUM_LAST) begin
                  w_next = c_DATA;
                  w_op   = c_OP_QRD;
               end else begin
                  w_op   = c_OP_WAIT;
               end
            end
         end
         c_DATA: begin
            if (w_done) begin
               if (w_data_last) begin
                  w_next = c_DONE;
               end else begin
                  w_launch = 1'b1;
                  w_op     = r_we ? c_OP_QWR : c_OP_QRD;
                  w_byte   = r_we ? bus.req_wdata : 8'h00;
               end
            end
         end
         c_DONE: begin
            w_next = c_GAP;
         end
         c_GAP: begin
            if (w_gap_hit) w_next = c_IDLE;
         end
         default: begin
            w_next = c_PWRUP;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         r_state     <= c_PWRUP;
         r_cnt       <= '0;
         r_dum       <= '0;
         r_busy      <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_start     <= 1'b0;
         r_op        <= c_OP_SPI;
         r_tx        <= '0;
         r_ce        <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state <= w_next;
         r_start <= w_launch;
         r_ce    <= ~w_ce_low_next;

         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (w_counting) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_launch) begin
            r_op   <= w_op;
            r_tx   <= w_byte;
            r_busy <= 1'b1;
         end else if (w_done) begin
            r_busy <= 1'b0;
         end

         if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_we    <= bus.req_we;
            r_wdata <= bus.req_wdata;
         end

         if (r_state != c_DUMMY) begin
            r_dum <= '0;
         end else if (w_done) begin
            r_dum <= r_dum + 1'b1;
         end

         if ((r_state == c_DATA) && w_done && !r_we) begin
            r_rdata <= bus.spi_rx_byte;
         end

`ifdef PSRAM_BURST_EN
         // Reads report every byte; writes report once when the frame closes.
         r_rsp_valid <= ((r_state == c_DONE) && r_we) ||
                        ((r_state == c_DATA) && w_done && !r_we);
`else
         r_rsp_valid <= (r_state == c_DONE);
`endif

         if ((r_state == c_GAP3) && (w_next == c_IDLE)) begin
            r_init_done <= 1'b1;
         end
      end
   end

`ifdef PSRAM_BURST_EN
   // wdata_pop asks the host to present the byte for the next write beat.
   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         r_len  <= '0;
         r_beat <= '0;
         r_pop  <= 1'b0;
      end else begin
         r_pop <= 1'b0;
         if (w_accept) begin
            r_len  <= bus.req_len;
            r_beat <= '0;
            r_pop  <= bus.req_we && (bus.req_len != 2'd0);
         end else if ((r_state == c_DATA) && w_done) begin
            r_beat <= r_beat + 2'd1;
            r_pop  <= r_we && !w_data_last && ((r_beat + 2'd1) != r_len);
         end
      end
   end

   assign bus.wdata_pop = r_pop;
`endif

   assign bus.req_ready   = w_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rdata;
   assign bus.init_done   = r_init_done;
   assign bus.spi_start   = r_start;
   assign bus.spi_op      = r_op;
   assign bus.spi_tx_byte = r_tx;
   assign bus.spi_ce      = r_ce;

endmodule
`default_nettype wire
